// File: rtl/bootrom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bootrom_arbiter
// Brief    : Two-master round-robin arbiter in front of a synchronous boot ROM
//            (1-cycle read latency) with a one-way ROM unmap control.
// Revision : 1.0 - initial release
// ============================================================================
module bootrom_arbiter #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic              m0_rdvalid,
    output logic              m1_rdvalid,
    output logic [31:0]       rddata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_rddata,
    input  logic              rom_disable,
    output logic              rom_enabled
);

    localparam logic c_OWNER_M0 = 1'b0;
    localparam logic c_OWNER_M1 = 1'b1;

    logic              r_rom_enabled;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_pipe_valid;
    logic              r_pipe_owner;
    logic              r_pipe_rom_en;   // ROM mapping state sampled at acceptance

    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept;
    logic [ADDR_W-1:0] w_rom_addr;
    logic              w_rdvalid0;
    logic              w_rdvalid1;

    // Grant selection: lone requester always wins, ties go to the master not granted last
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset) begin
            if (m0_req && m1_req) begin
                if (r_last_grant == c_OWNER_M1) begin
                    w_grant0 = 1'b1;
                end else begin
                    w_grant1 = 1'b1;
                end
            end else if (m0_req) begin
                w_grant0 = 1'b1;
            end else if (m1_req) begin
                w_grant1 = 1'b1;
            end
        end
    end

    assign w_accept = w_grant0 | w_grant1;

    // ROM address follows the accepted master, otherwise holds the last issued address
    always_comb begin
        w_rom_addr = r_last_addr;
        if (w_grant0) begin
            w_rom_addr = m0_addr;
        end else if (w_grant1) begin
            w_rom_addr = m1_addr;
        end
    end

    // Arbiter state and ROM mapping flag; unmapping is sticky until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rom_enabled <= 1'b1;
            r_last_grant  <= c_OWNER_M1;
            r_last_addr   <= '0;
        end else begin
            if (rom_disable) begin
                r_rom_enabled <= 1'b0;
            end
            if (w_accept) begin
                r_last_grant <= w_grant1 ? c_OWNER_M1 : c_OWNER_M0;
                r_last_addr  <= w_rom_addr;
            end
        end
    end

    // One-deep read pipeline tracking who owns the data returning next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_valid  <= 1'b0;
            r_pipe_owner  <= c_OWNER_M0;
            r_pipe_rom_en <= 1'b0;
        end else begin
            r_pipe_valid  <= w_accept;
            r_pipe_owner  <= w_grant1;
            r_pipe_rom_en <= r_rom_enabled;
        end
    end

    // A reset arriving while a read is in flight squashes its completion
    assign w_rdvalid0 = r_pipe_valid & (r_pipe_owner == c_OWNER_M0) & ~reset;
    assign w_rdvalid1 = r_pipe_valid & (r_pipe_owner == c_OWNER_M1) & ~reset;

    assign m0_ack      = w_grant0;
    assign m1_ack      = w_grant1;
    assign rom_addr    = w_rom_addr;
    assign rom_enabled = r_rom_enabled;
    assign m0_rdvalid  = w_rdvalid0;
    assign m1_rdvalid  = w_rdvalid1;
    // Data is zero when nothing is returning or the ROM was unmapped at acceptance
    assign rddata      = ((w_rdvalid0 | w_rdvalid1) && r_pipe_rom_en) ? rom_rddata : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_bootrom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bootrom_arbiter
// Brief    : Self-checking bench for bootrom_arbiter: vector table for
//            request/ack behaviour, scoreboard queue for read returns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bootrom_arbiter;

    localparam int ADDR_W = 9;

    logic              clk;
    logic              reset;
    logic              m0_req;
    logic              m1_req;
    logic [ADDR_W-1:0] m0_addr;
    logic [ADDR_W-1:0] m1_addr;
    logic              m0_ack;
    logic              m1_ack;
    logic              m0_rdvalid;
    logic              m1_rdvalid;
    logic [31:0]       rddata;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_rddata;
    logic              rom_disable;
    logic              rom_enabled;

    int checks = 0;
    int errors = 0;
    logic m_en;    // model of the ROM mapping flag

    typedef struct {
        logic              rst;
        logic              r0;
        logic              r1;
        logic [ADDR_W-1:0] a0;
        logic [ADDR_W-1:0] a1;
        logic              dis;
        logic              e0;
        logic              e1;
        logic [ADDR_W-1:0] ea;
        logic              ca;
    } vec_t;

    typedef struct {
        logic        owner;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    bootrom_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_req      (m0_req),
        .m1_req      (m1_req),
        .m0_addr     (m0_addr),
        .m1_addr     (m1_addr),
        .m0_ack      (m0_ack),
        .m1_ack      (m1_ack),
        .m0_rdvalid  (m0_rdvalid),
        .m1_rdvalid  (m1_rdvalid),
        .rddata      (rddata),
        .rom_addr    (rom_addr),
        .rom_rddata  (rom_rddata),
        .rom_disable (rom_disable),
        .rom_enabled (rom_enabled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] romf(input logic [ADDR_W-1:0] a);
        return 32'hB007_0000 + (32'(a) * 32'h0001_0101);
    endfunction

    // Synchronous ROM: registered output, one cycle of latency
    always @(posedge clk) rom_rddata <= romf(rom_addr);

    function automatic vec_t mk(input logic rst, input logic r0, input logic r1,
                                input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                                input logic dis, input logic e0, input logic e1,
                                input logic [ADDR_W-1:0] ea, input logic ca);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1;
        v.dis = dis; v.e0 = e0; v.e1 = e1; v.ea = ea; v.ca = ca;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Apply one vector for one cycle and check everything observable in it
    task automatic step(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = v.rst;
        m0_req      = v.r0;
        m1_req      = v.r1;
        m0_addr     = v.a0;
        m1_addr     = v.a1;
        rom_disable = v.dis;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (v.rst) begin
                chk("rdvalid_squashed", {30'b0, m1_rdvalid, m0_rdvalid}, 32'd0);
            end else begin
                chk("rdvalid", {30'b0, m1_rdvalid, m0_rdvalid}, e.owner ? 32'd2 : 32'd1);
                chk("rddata", rddata, e.data);
            end
        end else begin
            chk("rdvalid_idle", {30'b0, m1_rdvalid, m0_rdvalid}, 32'd0);
            chk("rddata_idle", rddata, 32'd0);
        end
        chk("acks", {30'b0, m1_ack, m0_ack}, {30'b0, v.e1, v.e0});
        if (v.ca) chk("rom_addr", 32'(rom_addr), 32'(v.ea));
        chk("rom_enabled", {31'b0, rom_enabled}, {31'b0, m_en});
        if (!v.rst && (v.e0 || v.e1)) begin
            e.owner = v.e1;
            e.data  = m_en ? romf(v.e1 ? v.a1 : v.a0) : 32'h0;
            sb.push_back(e);
        end
        if (v.rst) m_en = 1'b1;
        else if (v.dis) m_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
        m0_addr = '0; m1_addr = '0; rom_disable = 1'b0;
        m_en = 1'b1;
        repeat (2) @(posedge clk);

        // rst r0 r1 a0 a1 dis e0 e1 ea ca
        vecs.push_back(mk(1, 1, 1, 9'h010, 9'h020, 0, 0, 0, 9'h000, 0)); // held reqs ignored in reset
        vecs.push_back(mk(0, 1, 0, 9'h000, 9'h000, 0, 1, 0, 9'h000, 1)); // single m0 read of addr 0
        vecs.push_back(mk(0, 0, 0, 9'h1FF, 9'h1FF, 0, 0, 0, 9'h000, 1)); // idle: rom_addr holds
        vecs.push_back(mk(1, 0, 0, 9'h000, 9'h000, 0, 0, 0, 9'h000, 0));
        vecs.push_back(mk(0, 1, 1, 9'h010, 9'h020, 0, 1, 0, 9'h010, 1)); // tie after reset: m0 first
        vecs.push_back(mk(0, 1, 1, 9'h010, 9'h020, 0, 0, 1, 9'h020, 1));
        vecs.push_back(mk(0, 1, 1, 9'h010, 9'h020, 0, 1, 0, 9'h010, 1));
        vecs.push_back(mk(0, 1, 1, 9'h010, 9'h020, 0, 0, 1, 9'h020, 1));
        vecs.push_back(mk(0, 0, 1, 9'h000, 9'h078, 0, 0, 1, 9'h078, 1)); // m1 back-to-back burst
        vecs.push_back(mk(0, 0, 1, 9'h000, 9'h079, 0, 0, 1, 9'h079, 1));
        vecs.push_back(mk(0, 0, 1, 9'h000, 9'h07A, 0, 0, 1, 9'h07A, 1));
        vecs.push_back(mk(0, 0, 1, 9'h000, 9'h07B, 0, 0, 1, 9'h07B, 1));
        vecs.push_back(mk(0, 0, 0, 9'h003, 9'h004, 0, 0, 0, 9'h07B, 1));
        vecs.push_back(mk(0, 1, 0, 9'h005, 9'h000, 1, 1, 0, 9'h005, 1)); // disable with m0 acceptance
        vecs.push_back(mk(0, 0, 1, 9'h000, 9'h006, 0, 0, 1, 9'h006, 1)); // m1 read after unmap -> 0
        vecs.push_back(mk(0, 0, 0, 9'h000, 9'h000, 0, 0, 0, 9'h006, 1));
        vecs.push_back(mk(0, 1, 1, 9'h011, 9'h012, 0, 1, 0, 9'h011, 1)); // tie while unmapped
        vecs.push_back(mk(0, 1, 1, 9'h011, 9'h012, 0, 0, 1, 9'h012, 1));
        vecs.push_back(mk(0, 0, 0, 9'h000, 9'h000, 0, 0, 0, 9'h012, 1));

        foreach (vecs[i]) step(vecs[i]);

        // Reset right after an m1 acceptance: its read is squashed, then m0 wins the first tie
        step(mk(0, 0, 1, 9'h000, 9'h033, 0, 0, 1, 9'h033, 1));
        step(mk(1, 1, 1, 9'h044, 9'h055, 0, 0, 0, 9'h000, 0));
        step(mk(0, 1, 1, 9'h044, 9'h055, 0, 1, 0, 9'h044, 1));
        step(mk(0, 1, 1, 9'h044, 9'h055, 0, 0, 1, 9'h055, 1));
        step(mk(0, 0, 0, 9'h000, 9'h000, 0, 0, 0, 9'h055, 1));
        step(mk(0, 0, 0, 9'h000, 9'h000, 0, 0, 0, 9'h055, 1));

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bootrom_arbiter.md
BOOTROM_ARBITER -- requirements
Module: bootrom_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, giving the boot ROM word-address width.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, with reset synchronous and active-high.
REQ-004 The block SHALL have ports m0_req/m1_req, input, 1 each, read requests from fetch (m0) and data (m1) masters.
REQ-005 The block SHALL have ports m0_addr/m1_addr, input, ADDR_W each, the word address of each master's request.
REQ-006 The block SHALL have ports m0_ack/m1_ack, output, 1 each, asserted for exactly one cycle when that master's request is accepted.
REQ-007 The block SHALL have ports m0_rdvalid/m1_rdvalid, output, 1 each, asserted when that master's read data is valid.
REQ-008 The block SHALL have port rddata, output, 32, read data shared by both masters and qualified by m*_rdvalid.
REQ-009 The block SHALL have port rom_addr, output, ADDR_W, the address to the synchronous ROM (registered ROM output, 1-cycle read latency).
REQ-010 The block SHALL have port rom_rddata, input, 32, the ROM data valid one cycle after rom_addr is presented.
REQ-011 The block SHALL have port rom_disable, input, 1, a one-cycle pulse that unmaps the ROM after boot.
REQ-012 The block SHALL have port rom_enabled, output, 1, current ROM mapping state.

Function
REQ-013 Requests SHALL be level-held by the master until its ack; the arbiter SHALL never drop a held request.
REQ-014 At most one of m0_ack/m1_ack SHALL be asserted per cycle; ack is combinational from req and arbiter state in the acceptance cycle N.
REQ-015 In cycle N, rom_addr SHALL equal the accepted master's address; with no acceptance, rom_addr SHALL hold its previous value (registered last_addr).
REQ-016 In cycle N+1, the accepted master's rdvalid SHALL be 1 and rddata SHALL equal rom_rddata while rom_enabled was 1 in cycle N; otherwise rddata SHALL be 32'h00000000.
REQ-017 A single requester SHALL be accepted every cycle it requests (full throughput, back-to-back).
REQ-018 Simultaneous requests SHALL be resolved round-robin: grant the master not granted most recently; last_grant register updates on every ack.
REQ-019 A master SHALL never wait more than one cycle while the other is requesting continuously.
REQ-020 Owner of outstanding read SHALL be tracked in a 1-cycle pipeline register (valid, owner); rdvalid derived solely from it.
REQ-021 rom_enabled SHALL clear on the cycle after a rom_disable pulse and stay 0 until reset; a request accepted in the same cycle as the pulse SHALL still return ROM data.
REQ-022 While rom_enabled is 0, requests SHALL still be acked and completed with rddata 0.
REQ-023 Outputs not qualified by rdvalid (rddata) SHALL be 0 when both rdvalid are 0.

Reset
REQ-024 During reset, m0_ack, m1_ack, m0_rdvalid, m1_rdvalid SHALL be 0 and no request is accepted.
REQ-025 Reset SHALL set rom_enabled=1, last_grant=m1 (so m0 wins the first tie), rom_addr=0, pipeline valid=0.
REQ-026 Reset asserted the cycle after an acceptance SHALL suppress that acceptance's rdvalid.
REQ-027 In the first cycle after reset deasserts, pending requests SHALL be arbitrated normally.

Verification
REQ-028 Reset, then m0_req=1 addr 0x000 only -> m0_ack in cycle 0, m0_rdvalid cycle 1 with rddata=ROM[0].
REQ-029 Both request continuously, addrs 0x010/0x020 -> acks alternate m0,m1,m0,... starting m0; rdvalid/rddata follow one cycle later with matching data.
REQ-030 m1 requests 4 consecutive addrs 0x078..0x07B alone -> 4 acks in 4 consecutive cycles, 4 rdvalid with ROM data, no bubbles.
REQ-031 rom_disable pulse coincident with m0 acceptance -> that read returns ROM data; next m1 read returns 0, rom_enabled=0 until reset.
REQ-032 Assert reset the cycle after an m1 acceptance -> no m1_rdvalid; after release rom_enabled=1 and m0 wins first tie.
